// File: rtl/ide_multisector_buffer.sv
// Ring of NBUF sector buffers between the IDE host data register and the MCU word stream.
// Handles multi-sector read/write transfers with sector counting, DRQ and per-sector interrupt.
module ide_multisector_buffer #(
  parameter int unsigned SECTOR_WORDS = 256,
  parameter int unsigned WAW          = 8,
  parameter int unsigned NBUF         = 2,
  parameter int unsigned BAW          = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_write,
  input  logic [7:0]  count,
  input  logic        abort,
  input  logic        host_rd,
  input  logic        host_wr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        drq,
  output logic        host_irq,
  input  logic        irq_clr,
  input  logic        mcu_wr,
  input  logic [15:0] mcu_wdata,
  input  logic        mcu_rd,
  output logic [15:0] mcu_rdata,
  output logic        mcu_req,
  output logic        busy,
  output logic [8:0]  sectors_left,
  output logic        err
);

  localparam int unsigned AW    = BAW + WAW;
  localparam int unsigned FCW   = BAW + 1;
  localparam int unsigned DEPTH = NBUF * SECTOR_WORDS;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [15:0] mem [DEPTH];

  logic [0:0]     state_q, state_d;
  logic           mode_q, mode_d;
  logic [8:0]     total_q, total_d;
  logic [8:0]     started_q, started_d;
  logic [8:0]     sectors_left_q, sectors_left_d;
  logic [BAW-1:0] pb_q, pb_d, cb_q, cb_d;
  logic [WAW-1:0] pw_q, pw_d, cw_q, cw_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           drq_q, drq_d;
  logic           mcu_req_q, mcu_req_d;
  logic           busy_q, busy_d;
  logic           host_irq_q, host_irq_d;
  logic           err_q, err_d;
  logic [15:0]    host_rdata_q, host_rdata_d;
  logic [15:0]    mcu_rdata_q, mcu_rdata_d;

  logic           active, prod_en, cons_en, prod_stb, cons_stb;
  logic           prod_fire, cons_fire, p_wrap, c_wrap, bad_stb, irq_set;
  logic           act_nx, pen_nx, cen_nx;
  logic [AW-1:0]  p_addr, c_addr;
  logic [15:0]    prod_data, cons_data;

  // Enables are derived from the same state the registered flow-control outputs reflect
  assign active    = (state_q == S_ACTIVE);
  assign prod_en   = active && (fc_q < FCW'(NBUF)) && (started_q < total_q);
  assign cons_en   = active && (fc_q != '0);
  assign prod_stb  = mode_q ? host_wr : mcu_wr;
  assign cons_stb  = mode_q ? mcu_rd : host_rd;
  assign prod_fire = prod_stb && prod_en;
  assign cons_fire = cons_stb && cons_en;
  assign p_wrap    = prod_fire && (pw_q == WAW'(SECTOR_WORDS - 1));
  assign c_wrap    = cons_fire && (cw_q == WAW'(SECTOR_WORDS - 1));
  assign bad_stb   = (mode_q ? (host_rd | mcu_wr) : (host_wr | mcu_rd))
                   | (prod_stb & ~prod_en) | (cons_stb & ~cons_en);
  // Read mode interrupts every sector; write mode only once the MCU drains the final one
  assign irq_set   = c_wrap && (!mode_q || (sectors_left_q == 9'd1));
  assign p_addr    = {pb_q, pw_q};
  assign c_addr    = {cb_q, cw_q};
  assign prod_data = mode_q ? host_wdata : mcu_wdata;
  assign cons_data = mem[c_addr];

  always_ff @(posedge clk) begin
    if (prod_fire) mem[p_addr] <= prod_data;
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    total_d        = total_q;
    started_d      = started_q;
    sectors_left_d = sectors_left_q;
    pb_d           = pb_q;
    pw_d           = pw_q;
    cb_d           = cb_q;
    cw_d           = cw_q;
    fc_d           = fc_q + FCW'(p_wrap) - FCW'(c_wrap);
    host_irq_d     = (host_irq_q && !irq_clr) || irq_set;
    err_d          = err_q || bad_stb;
    host_rdata_d   = host_rdata_q;
    mcu_rdata_d    = mcu_rdata_q;

    if (prod_fire) begin
      pw_d = pw_q + WAW'(1);
      if (p_wrap) begin
        pw_d      = '0;
        pb_d      = (pb_q == BAW'(NBUF - 1)) ? '0 : pb_q + BAW'(1);
        started_d = started_q + 9'd1;
      end
    end

    if (cons_fire) begin
      if (mode_q) mcu_rdata_d = cons_data;
      else        host_rdata_d = cons_data;
      cw_d = cw_q + WAW'(1);
      if (c_wrap) begin
        cw_d           = '0;
        cb_d           = (cb_q == BAW'(NBUF - 1)) ? '0 : cb_q + BAW'(1);
        sectors_left_d = sectors_left_q - 9'd1;
        if (sectors_left_q == 9'd1) state_d = S_IDLE;
      end
    end

    if (start) begin
      if (active) begin
        err_d = 1'b1;
      end else begin
        state_d        = S_ACTIVE;
        mode_d         = mode_write;
        total_d        = (count == 8'd0) ? 9'd256 : {1'b0, count};
        sectors_left_d = (count == 8'd0) ? 9'd256 : {1'b0, count};
        started_d      = '0;
        pb_d           = '0;
        pw_d           = '0;
        cb_d           = '0;
        cw_d           = '0;
        fc_d           = '0;
        err_d          = 1'b0;
      end
    end

    if (abort) begin
      state_d   = S_IDLE;
      started_d = '0;
      pb_d      = '0;
      pw_d      = '0;
      cb_d      = '0;
      cw_d      = '0;
      fc_d      = '0;
    end

    // Flow-control outputs follow the next-state values so they settle one cycle after the event
    act_nx    = (state_d == S_ACTIVE);
    pen_nx    = act_nx && (fc_d < FCW'(NBUF)) && (started_d < total_d);
    cen_nx    = act_nx && (fc_d != '0);
    drq_d     = mode_d ? pen_nx : cen_nx;
    mcu_req_d = mode_d ? cen_nx : pen_nx;
    busy_d    = act_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mode_q         <= 1'b0;
      total_q        <= '0;
      started_q      <= '0;
      sectors_left_q <= '0;
      pb_q           <= '0;
      pw_q           <= '0;
      cb_q           <= '0;
      cw_q           <= '0;
      fc_q           <= '0;
      drq_q          <= 1'b0;
      mcu_req_q      <= 1'b0;
      busy_q         <= 1'b0;
      host_irq_q     <= 1'b0;
      err_q          <= 1'b0;
      host_rdata_q   <= '0;
      mcu_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      total_q        <= total_d;
      started_q      <= started_d;
      sectors_left_q <= sectors_left_d;
      pb_q           <= pb_d;
      pw_q           <= pw_d;
      cb_q           <= cb_d;
      cw_q           <= cw_d;
      fc_q           <= fc_d;
      drq_q          <= drq_d;
      mcu_req_q      <= mcu_req_d;
      busy_q         <= busy_d;
      host_irq_q     <= host_irq_d;
      err_q          <= err_d;
      host_rdata_q   <= host_rdata_d;
      mcu_rdata_q    <= mcu_rdata_d;
    end
  end

  assign host_rdata   = host_rdata_q;
  assign mcu_rdata    = mcu_rdata_q;
  assign drq          = drq_q;
  assign mcu_req      = mcu_req_q;
  assign busy         = busy_q;
  assign host_irq     = host_irq_q;
  assign err          = err_q;
  assign sectors_left = sectors_left_q;

endmodule

// File: tb/tb_ide_multisector_buffer.sv
// Directed bench for ide_multisector_buffer with 4-word sectors and two buffers.
module tb_ide_multisector_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mode_write, abort;
  logic [7:0]  count;
  logic        host_rd, host_wr, irq_clr, mcu_wr, mcu_rd;
  logic [15:0] host_wdata, mcu_wdata;
  logic [15:0] host_rdata, mcu_rdata;
  logic        drq, host_irq, mcu_req, busy, err;
  logic [8:0]  sectors_left;

  int errors = 0;
  int checks = 0;

  ide_multisector_buffer #(
    .SECTOR_WORDS(4), .WAW(2), .NBUF(2), .BAW(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode_write(mode_write), .count(count),
    .abort(abort), .host_rd(host_rd), .host_wr(host_wr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .drq(drq), .host_irq(host_irq), .irq_clr(irq_clr),
    .mcu_wr(mcu_wr), .mcu_wdata(mcu_wdata), .mcu_rd(mcu_rd), .mcu_rdata(mcu_rdata),
    .mcu_req(mcu_req), .busy(busy), .sectors_left(sectors_left), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic mw, input logic [7:0] cnt);
    mode_write = mw; count = cnt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic do_irq_clr();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  task automatic mcu_write(input logic [15:0] d);
    mcu_wdata = d; mcu_wr = 1'b1;
    tick();
    mcu_wr = 1'b0;
    tick();
  endtask

  task automatic host_write(input logic [15:0] d);
    host_wdata = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
    tick();
  endtask

  task automatic host_read(output logic [15:0] d);
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    d = host_rdata;
    tick();
  endtask

  task automatic mcu_read(output logic [15:0] d);
    mcu_rd = 1'b1;
    tick();
    mcu_rd = 1'b0;
    d = mcu_rdata;
    tick();
  endtask

  task automatic test_reset();
    checks++; if ({drq, mcu_req, busy, host_irq, err} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got=%b exp=00000", {drq, mcu_req, busy, host_irq, err}); end
    checks++; if (sectors_left !== 9'd0) begin errors++;
      $display("FAIL reset_sectors_left got=%0d exp=0", sectors_left); end
    checks++; if (host_rdata !== 16'h0 || mcu_rdata !== 16'h0) begin errors++;
      $display("FAIL reset_rdata got=%h/%h exp=0000/0000", host_rdata, mcu_rdata); end
  endtask

  task automatic test_read_mode();
    logic [15:0] d;
    int irqs = 0;
    do_start(1'b0, 8'd3);
    checks++; if ({busy, mcu_req, drq} !== 3'b110 || sectors_left !== 9'd3) begin errors++;
      $display("FAIL rd_start got busy/req/drq=%b sl=%0d exp=110 sl=3", {busy, mcu_req, drq}, sectors_left); end
    for (int i = 0; i < 8; i++) begin
      mcu_write(16'h0100 + 16'(i));
      if (i == 2) begin
        checks++; if (drq !== 1'b0) begin errors++; $display("FAIL rd_drq_early got=%b exp=0", drq); end
      end
      if (i == 3) begin
        checks++; if (drq !== 1'b1) begin errors++; $display("FAIL rd_drq_rise got=%b exp=1", drq); end
      end
    end
    checks++; if (mcu_req !== 1'b0) begin errors++; $display("FAIL rd_req_full got=%b exp=0", mcu_req); end
    for (int i = 0; i < 4; i++) begin
      host_read(d);
      checks++; if (d !== 16'h0100 + 16'(i)) begin errors++;
        $display("FAIL rd_data%0d got=%h exp=%h", i, d, 16'h0100 + 16'(i)); end
    end
    if (host_irq === 1'b1) irqs++;
    checks++; if (mcu_req !== 1'b1 || sectors_left !== 9'd2) begin errors++;
      $display("FAIL rd_drain1 got req=%b sl=%0d exp req=1 sl=2", mcu_req, sectors_left); end
    do_irq_clr();
    checks++; if (host_irq !== 1'b0) begin errors++; $display("FAIL rd_irq_clr got=%b exp=0", host_irq); end
    for (int i = 8; i < 12; i++) mcu_write(16'h0100 + 16'(i));
    checks++; if (mcu_req !== 1'b0) begin errors++; $display("FAIL rd_req_total got=%b exp=0", mcu_req); end
    for (int i = 4; i < 12; i++) begin
      host_read(d);
      checks++; if (d !== 16'h0100 + 16'(i)) begin errors++;
        $display("FAIL rd_data%0d got=%h exp=%h", i, d, 16'h0100 + 16'(i)); end
      if (i == 7 || i == 11) begin
        if (host_irq === 1'b1) irqs++;
        do_irq_clr();
      end
      if (i == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_hold got=%b exp=1", busy); end
      end
    end
    checks++; if (irqs !== 3) begin errors++; $display("FAIL rd_irq_count got=%0d exp=3", irqs); end
    checks++; if ({busy, drq, mcu_req} !== 3'b000 || sectors_left !== 9'd0) begin errors++;
      $display("FAIL rd_end got busy/drq/req=%b sl=%0d exp=000 sl=0", {busy, drq, mcu_req}, sectors_left); end
  endtask

  task automatic test_write_mode();
    logic [15:0] d;
    do_start(1'b1, 8'd2);
    checks++; if ({drq, mcu_req} !== 2'b10) begin errors++;
      $display("FAIL wr_start got drq/req=%b exp=10", {drq, mcu_req}); end
    for (int i = 0; i < 8; i++) begin
      host_write(16'hA000 + 16'(i));
      if (i == 3) begin
        checks++; if (mcu_req !== 1'b1 || drq !== 1'b1) begin errors++;
          $display("FAIL wr_req_rise got req/drq=%b%b exp=11", mcu_req, drq); end
      end
    end
    checks++; if (drq !== 1'b0) begin errors++; $display("FAIL wr_drq_fall got=%b exp=0", drq); end
    repeat (5) tick();
    checks++; if (host_irq !== 1'b0 || sectors_left !== 9'd2) begin errors++;
      $display("FAIL wr_stall got irq=%b sl=%0d exp irq=0 sl=2", host_irq, sectors_left); end
    for (int i = 0; i < 8; i++) begin
      mcu_read(d);
      checks++; if (d !== 16'hA000 + 16'(i)) begin errors++;
        $display("FAIL wr_data%0d got=%h exp=%h", i, d, 16'hA000 + 16'(i)); end
      if (i == 3) begin
        checks++; if (sectors_left !== 9'd1 || host_irq !== 1'b0) begin errors++;
          $display("FAIL wr_mid got sl=%0d irq=%b exp sl=1 irq=0", sectors_left, host_irq); end
      end
    end
    checks++; if (sectors_left !== 9'd0 || host_irq !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL wr_end got sl=%0d irq=%b busy=%b exp sl=0 irq=1 busy=0", sectors_left, host_irq, busy); end
    do_irq_clr();
  endtask

  task automatic test_count_zero();
    logic [15:0] d;
    do_start(1'b0, 8'd0);
    checks++; if (sectors_left !== 9'd256) begin errors++;
      $display("FAIL cnt0_start got=%0d exp=256", sectors_left); end
    for (int i = 0; i < 4; i++) mcu_write(16'h0700 + 16'(i));
    for (int i = 0; i < 4; i++) host_read(d);
    checks++; if (sectors_left !== 9'd255 || d !== 16'h0703) begin errors++;
      $display("FAIL cnt0_dec got sl=%0d d=%h exp sl=255 d=0703", sectors_left, d); end
    do_abort();
    do_irq_clr();
  endtask

  task automatic test_abort();
    logic [15:0] d;
    do_start(1'b0, 8'd1);
    for (int i = 0; i < 4; i++) mcu_write(16'h0200 + 16'(i));
    host_read(d);
    host_read(d);
    checks++; if (d !== 16'h0201) begin errors++; $display("FAIL ab_pre got=%h exp=0201", d); end
    do_abort();
    checks++; if ({busy, drq, mcu_req} !== 3'b000) begin errors++;
      $display("FAIL ab_flags got=%b exp=000", {busy, drq, mcu_req}); end
    do_start(1'b0, 8'd1);
    for (int i = 0; i < 4; i++) mcu_write(16'h0300 + 16'(i));
    host_read(d);
    checks++; if (d !== 16'h0300) begin errors++; $display("FAIL ab_restart got=%h exp=0300", d); end
    for (int i = 1; i < 4; i++) host_read(d);
    checks++; if (d !== 16'h0303 || busy !== 1'b0) begin errors++;
      $display("FAIL ab_finish got d=%h busy=%b exp d=0303 busy=0", d, busy); end
    do_irq_clr();
  endtask

  task automatic test_err();
    logic [15:0] d;
    do_start(1'b0, 8'd1);
    checks++; if (err !== 1'b0 || drq !== 1'b0) begin errors++;
      $display("FAIL err_pre got err=%b drq=%b exp 0 0", err, drq); end
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    tick();
    checks++; if (err !== 1'b1 || host_rdata !== 16'h0303) begin errors++;
      $display("FAIL err_set got err=%b rdata=%h exp err=1 rdata=0303", err, host_rdata); end
    for (int i = 0; i < 4; i++) mcu_write(16'h0400 + 16'(i));
    host_read(d);
    checks++; if (d !== 16'h0400) begin errors++; $display("FAIL err_ptr got=%h exp=0400", d); end
    for (int i = 1; i < 4; i++) host_read(d);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL err_sticky got err=%b busy=%b exp 1 0", err, busy); end
    do_start(1'b0, 8'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err); end
    do_abort();
    do_irq_clr();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    do_start(1'b0, 8'd3);
    for (int i = 0; i < 7; i++) mcu_write(16'h0500 + 16'(i));
    for (int i = 0; i < 3; i++) host_read(d);
    checks++; if (host_irq !== 1'b0 || d !== 16'h0502) begin errors++;
      $display("FAIL b2b_pre got irq=%b d=%h exp irq=0 d=0502", host_irq, d); end
    mcu_wdata = 16'h0507; mcu_wr = 1'b1; host_rd = 1'b1; irq_clr = 1'b1;
    tick();
    mcu_wr = 1'b0; host_rd = 1'b0; irq_clr = 1'b0;
    checks++; if (host_rdata !== 16'h0503 || host_irq !== 1'b1) begin errors++;
      $display("FAIL b2b_sim got rdata=%h irq=%b exp rdata=0503 irq=1", host_rdata, host_irq); end
    checks++; if ({drq, mcu_req} !== 2'b11 || sectors_left !== 9'd2) begin errors++;
      $display("FAIL b2b_fc got drq/req=%b sl=%0d exp=11 sl=2", {drq, mcu_req}, sectors_left); end
    tick();
    for (int i = 4; i < 8; i++) begin
      host_read(d);
      checks++; if (d !== 16'h0500 + 16'(i)) begin errors++;
        $display("FAIL b2b_data%0d got=%h exp=%h", i, d, 16'h0500 + 16'(i)); end
    end
    checks++; if (drq !== 1'b0 || mcu_req !== 1'b1) begin errors++;
      $display("FAIL b2b_empty got drq=%b req=%b exp 0 1", drq, mcu_req); end
    do_abort();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; mode_write = 1'b0; count = 8'd0; abort = 1'b0;
    host_rd = 1'b0; host_wr = 1'b0; host_wdata = 16'h0; irq_clr = 1'b0;
    mcu_wr = 1'b0; mcu_rd = 1'b0; mcu_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    test_reset();
    test_read_mode();
    test_write_mode();
    test_count_zero();
    test_abort();
    test_err();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
